// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - op/state encodings and decode helpers for the HI/LO multiply controller
package mul_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MUL   = 4'd1,
    MULT  = 4'd2,
    MULTU = 4'd3,
    MADD  = 4'd4,
    MADDU = 4'd5,
    MSUB  = 4'd6,
    MSUBU = 4'd7,
    MFHI  = 4'd8,
    MFLO  = 4'd9,
    MTHI  = 4'd10,
    MTLO  = 4'd11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } mul_state_e;

  // One bit per op encoding; bit n set means op n has the property.
  localparam logic [15:0] MUL_CLASS_MASK = 16'h00FE;
  localparam logic [15:0] SIGNED_MASK    = 16'h0056;
  localparam logic [15:0] ACC_MASK       = 16'h00F0;
  localparam logic [15:0] SUB_MASK       = 16'h00C0;

  function automatic logic is_mul_class(input logic [3:0] op);
    return MUL_CLASS_MASK[op];
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return SIGNED_MASK[op];
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return ACC_MASK[op];
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return SUB_MASK[op];
  endfunction

endpackage

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - EX-stage multiply controller: drives the 1-cycle multiplier,
// owns HI/LO, performs MADD/MSUB accumulation and stalls until the op completes.
module mul_hilo_ctrl
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mul_start_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_result_i,
  input  logic        mul_ready_i
);

  mul_state_e  state_q, state_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod_q, prod_d, acc_q, acc_d;
  logic        abort;

  // Operands and op are held stable by upstream while stalled, so pass them straight through.
  assign mul_a_o      = opdata1_i;
  assign mul_b_o      = opdata2_i;
  assign mul_signed_o = is_signed(op_i);
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign abort        = flush | ~valid_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    stall_o     = 1'b0;
    result_o    = '0;
    mul_start_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush) begin
          if (is_mul_class(op_i)) begin
            mul_start_o = 1'b1;
            stall_o     = 1'b1;
            state_d     = WAIT;
          end else begin
            case (op_i)
              MFHI:    result_o = hi_q;
              MFLO:    result_o = lo_q;
              MTHI:    hi_d = opdata1_i;
              MTLO:    lo_d = opdata1_i;
              default: ;
            endcase
          end
        end
      end
      WAIT: begin
        // An abort wins over a ready arriving in the same cycle.
        if (abort) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          if (mul_ready_i) begin
            prod_d  = mul_result_i;
            state_d = is_acc(op_i) ? ACC : DONE;
          end
        end
      end
      ACC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          stall_o = 1'b1;
          acc_d   = is_sub(op_i) ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!abort) begin
          if (op_i == MUL) begin
            result_o = prod_q[31:0];
          end else if (is_acc(op_i)) begin
            {hi_d, lo_d} = acc_q;
          end else begin
            {hi_d, lo_d} = prod_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - directed bench for mul_hilo_ctrl with a behavioural 1-cycle multiplier
module tb_mul_hilo_ctrl;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, valid_i;
  logic [3:0]  op_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        stall_o, mul_start_o, mul_signed_o;
  logic [31:0] result_o, hi_o, lo_o, mul_a_o, mul_b_o;
  logic [63:0] mul_result;
  logic        mul_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_hilo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .valid_i      (valid_i),
    .op_i         (op_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .stall_o      (stall_o),
    .result_o     (result_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .mul_start_o  (mul_start_o),
    .mul_signed_o (mul_signed_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_result_i (mul_result),
    .mul_ready_i  (mul_ready)
  );

  function automatic logic [63:0] model_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  always @(posedge clk) begin
    if (rst || flush) mul_ready <= 1'b0;
    else              mul_ready <= mul_start_o;
    if (rst)              mul_result <= '0;
    else if (mul_start_o) mul_result <= model_mul(mul_a_o, mul_b_o, mul_signed_o);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Single-cycle op (MTHI/MTLO/MFHI/MFLO/NOP): checks result and no-stall in its cycle.
  task automatic one_cycle(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] exp_res);
    valid_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = '0;
    #1;
    chk({tag, "_stall"}, 64'(stall_o), 64'd0);
    chk({tag, "_result"}, 64'(result_o), 64'(exp_res));
    tick();
    valid_i = 1'b0; op_i = NOP; opdata1_i = '0;
  endtask

  // Multiply-class op lasting n cycles; the last cycle (DONE) must release the stall.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic exp_sgn, input logic [31:0] exp_res);
    valid_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
    for (int i = 0; i < n; i++) begin
      #1;
      chk($sformatf("%s_stall%0d", tag, i), 64'(stall_o), (i < n - 1) ? 64'd1 : 64'd0);
      chk($sformatf("%s_start%0d", tag, i), 64'(mul_start_o), (i == 0) ? 64'd1 : 64'd0);
      chk($sformatf("%s_result%0d", tag, i), 64'(result_o), (i == n - 1) ? 64'(exp_res) : 64'd0);
      if (i == 0) chk({tag, "_signed"}, 64'(mul_signed_o), 64'(exp_sgn));
      tick();
    end
    valid_i = 1'b0; op_i = NOP; opdata1_i = '0; opdata2_i = '0;
  endtask

  task automatic chk_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    chk({tag, "_hi"}, 64'(hi_o), 64'(hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(lo));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_i = 1'b0; op_i = NOP; opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_result", 64'(result_o), 64'd0);
    chk("rst_start", 64'(mul_start_o), 64'd0);
    chk("rst_signed", 64'(mul_signed_o), 64'd0);
    chk_hilo("rst", 32'h0, 32'h0);
    rst = 1'b0;
    tick();

    run_op("mult", MULT, 32'hFFFFFFFF, 32'h00000002, 3, 1'b1, 32'h0);
    #1 chk_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFE);

    run_op("multu", MULTU, 32'hFFFFFFFF, 32'h00000002, 3, 1'b0, 32'h0);
    #1 chk_hilo("multu", 32'h00000001, 32'hFFFFFFFE);

    one_cycle("mthi0", MTHI, 32'h0, 32'h0);
    one_cycle("mtlo_ff", MTLO, 32'hFFFFFFFF, 32'h0);
    run_op("maddu", MADDU, 32'h1, 32'h1, 4, 1'b0, 32'h0);
    #1 chk_hilo("maddu", 32'h00000001, 32'h00000000);

    one_cycle("mthi0b", MTHI, 32'h0, 32'h0);
    one_cycle("mtlo0b", MTLO, 32'h0, 32'h0);
    run_op("msub", MSUB, 32'h3, 32'h2, 4, 1'b1, 32'h0);
    #1 chk_hilo("msub", 32'hFFFFFFFF, 32'hFFFFFFFA);

    run_op("mul", MUL, 32'h7, 32'hFFFFFFFD, 3, 1'b1, 32'hFFFFFFEB);
    #1 chk_hilo("mul", 32'hFFFFFFFF, 32'hFFFFFFFA);
    one_cycle("mflo", MFLO, 32'h0, 32'hFFFFFFFA);
    one_cycle("nop", NOP, 32'hDEAD, 32'h0);

    // MADD aborted by flush in ACC.
    one_cycle("mthi5", MTHI, 32'h5, 32'h0);
    one_cycle("mtlo5", MTLO, 32'h5, 32'h0);
    valid_i = 1'b1; op_i = MADD; opdata1_i = 32'h2; opdata2_i = 32'h3;
    tick();
    tick();
    flush = 1'b1;
    #1 chk("flush_acc_stall", 64'(stall_o), 64'd0);
    tick();
    flush = 1'b0; valid_i = 1'b0; op_i = NOP;
    #1;
    chk("flush_idle_stall", 64'(stall_o), 64'd0);
    chk_hilo("flush", 32'h5, 32'h5);
    tick();
    #1 chk_hilo("flush_later", 32'h5, 32'h5);

    // MULT aborted by valid_i dropping in WAIT while ready arrives.
    valid_i = 1'b1; op_i = MULT; opdata1_i = 32'h9; opdata2_i = 32'h9;
    tick();
    valid_i = 1'b0;
    #1 chk("vdrop_stall", 64'(stall_o), 64'd0);
    repeat (3) tick();
    chk_hilo("vdrop", 32'h5, 32'h5);

    one_cycle("mthi1234", MTHI, 32'h1234, 32'h0);
    one_cycle("mfhi", MFHI, 32'h0, 32'h1234);

    // MFHI right after MADD sees the committed accumulation: {5,5} + 2*3.
    one_cycle("mthi5b", MTHI, 32'h5, 32'h0);
    run_op("madd", MADD, 32'h2, 32'h3, 4, 1'b1, 32'h0);
    one_cycle("mfhi_madd", MFHI, 32'h0, 32'h5);
    one_cycle("mflo_madd", MFLO, 32'h0, 32'hB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
